seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte width serialised per handshake.
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream has a byte on in_data.
REQ-006 SHALL have port in_data  input  DATA_W  byte to scan, MSB first.
REQ-007 SHALL have port in_last  input  1  qualifies the byte as the last of the frame.
REQ-008 SHALL have port in_ready  output  1  the block accepts a byte this cycle.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when frame scan completes.
REQ-011 SHALL have port match_cnt  output  CNT_W  number of "101" occurrences in the current or last frame.

Function
REQ-012 SHALL use FSM states IDLE, LOAD, SHIFT, DONE.
REQ-013 SHALL accept a byte only when in_valid && in_ready; in_ready SHALL be 1 in IDLE and LOAD, 0 in SHIFT and DONE.
REQ-014 SHALL, on acceptance in IDLE, clear match_cnt, reset the detector to its initial state, latch in_data/in_last and go to SHIFT.
REQ-015 SHALL, on acceptance in LOAD, latch in_data/in_last, keep detector state and match_cnt, and go to SHIFT.
REQ-016 SHALL, in SHIFT, feed exactly one bit per cycle (MSB first) to the detector for DATA_W consecutive cycles.
REQ-017 SHALL, after the last bit, go to DONE if the latched in_last is 1, else to LOAD.
REQ-018 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-019 SHALL detect "101" with overlap: after a match, the trailing 1 starts the next candidate ("10101" = 2 matches).
REQ-020 SHALL detect patterns spanning byte boundaries within one frame; SHALL NOT carry detector state across frames.
REQ-021 SHALL increment match_cnt at the end of each SHIFT cycle whose bit completes a match, saturating at 2^CNT_W-1.
REQ-022 SHALL hold match_cnt stable from DONE until the first byte of the next frame is accepted.
REQ-023 SHALL produce done at cycle T+DATA_W+1 when the last byte is accepted at cycle T (T+9 for DATA_W=8).
REQ-024 SHALL, while waiting in LOAD with in_valid low, hold all state indefinitely.

Reset
REQ-025 SHALL, on reset high at a clock edge, go to IDLE and set in_ready=1, busy=0, done=0, match_cnt=0, detector to initial state, regardless of current state.
REQ-026 SHALL discard any partially scanned frame on reset; no done pulse SHALL follow.

Structure
REQ-027 SHALL place FSM state encodings and detector state encodings (S0/S1/S2) in a shared package, seq_scan_pkg.
REQ-028 SHALL instantiate one sub-module, seq101_det, holding detector state with inputs clk, reset, clr, bit_en, bit_in and a match output.
REQ-029 SHALL keep bit counter, shift register and match counter in seq_scan_ctrl.

Verification
REQ-030 Single frame 8'b1010_1000, in_last=1, accepted at T -> done=1 at T+9, match_cnt=2.
REQ-031 Two-byte frame 8'h01 then 8'h40 (last) -> match_cnt=1 (cross-boundary match); separate frames 8'h01 (last), then 8'h40 (last) -> 0 for each.
REQ-032 Frame of 70 bytes 8'hAA -> match_cnt=255 (saturated; 64 bytes would give exactly 255 unsaturated).
REQ-033 in_valid held high during SHIFT -> in_ready=0, no byte consumed until LOAD; byte count accepted equals bytes sent.
REQ-034 reset asserted at the 4th SHIFT cycle of 8'hFF/8'h05 frame -> next cycle IDLE, match_cnt=0, no done; a subsequent 8'h05 (last) frame -> match_cnt=1.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// ============================================================================
// Module  : seq_scan_pkg
// Brief   : Shared state encodings for the 101-pattern frame scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // S1: last bit was 1; S2: last two bits were 1,0
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_e;

endpackage

`default_nettype wire

// File: rtl/seq101_det.sv
// ============================================================================
// Module  : seq101_det
// Brief   : Overlapping "101" detector, one bit per enabled cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq101_det
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    det_state_e state_q;
    det_state_e state_d;

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (bit_en) begin
            unique case (state_q)
                S0: state_d = bit_in ? S1 : S0;
                S1: state_d = bit_in ? S1 : S2;
                S2: begin
                    // The completing 1 is also the start of the next candidate
                    state_d = bit_in ? S1 : S0;
                    match   = bit_in;
                end
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
// ============================================================================
// Module  : seq_scan_ctrl
// Brief   : Serialises framed bytes MSB first and counts "101" occurrences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int              BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    scan_state_e       state_q,    state_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              last_q,     last_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic accept;
    logic det_clr;
    logic det_en;
    logic det_match;

    assign accept  = in_valid && in_ready_q;
    assign det_clr = accept && (state_q == IDLE);
    assign det_en  = (state_q == SHIFT);

    seq101_det u_det (
        .clk    (clk),
        .reset  (reset),
        .clr    (det_clr),
        .bit_en (det_en),
        .bit_in (shreg_q[DATA_W-1]),
        .match  (det_match)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    shreg_d   = in_data;
                    last_d    = in_last;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                    if (state_q == IDLE) begin
                        cnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (det_match && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = last_q ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it
        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// ============================================================================
// Module  : tb_seq_scan_ctrl
// Brief   : Directed self-checking bench for seq_scan_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] match_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    seq_scan_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a byte and returns #1 after the edge that accepted it
    task automatic send(input logic [7:0] d, input logic last, input bit hold);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) chk("ready_wait", w, 0);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int a0;
        int seen;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        tick(2);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy",  busy,     0);
        chk("rst_done",  done,     0);
        chk("rst_cnt",   match_cnt, 0);
        reset = 1'b0;
        tick();

        // Single-byte frame, two overlapping matches, latency check
        send(8'hA8, 1'b1, 1'b0);
        chk("a8_busy",  busy,     1);
        chk("a8_ready", in_ready, 0);
        wait_done(n);
        chk("a8_latency", n, 8);
        chk("a8_cnt", match_cnt, 2);
        tick();
        chk("a8_done_pulse", done, 0);
        chk("a8_idle_busy",  busy, 0);
        chk("a8_idle_ready", in_ready, 1);
        chk("a8_cnt_hold",   match_cnt, 2);

        // Cross-boundary match with a long idle wait in LOAD
        send(8'h01, 1'b0, 1'b0);
        tick(20);
        chk("load_busy",  busy,     1);
        chk("load_ready", in_ready, 1);
        chk("load_done",  done,     0);
        send(8'h40, 1'b1, 1'b0);
        wait_done(n);
        chk("x_done_seen", done, 1);
        chk("x_cnt", match_cnt, 1);

        // Same bytes as separate frames: detector must not carry over
        send(8'h01, 1'b1, 1'b0);
        wait_done(n);
        chk("sep1_cnt", match_cnt, 0);
        send(8'h40, 1'b1, 1'b0);
        wait_done(n);
        chk("sep2_cnt", match_cnt, 0);

        // 70 bytes of AA with in_valid held high throughout
        a0 = n_acc;
        for (int i = 0; i < 70; i++) begin
            send(8'hAA, (i == 69), 1'b1);
            if (i == 0) chk("hold_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        wait_done(n);
        chk("sat_done_seen", done, 1);
        chk("sat_cnt", match_cnt, 255);
        chk("hold_acc", n_acc - a0, 70);

        // 64 bytes of AA reach 255 without saturating
        for (int i = 0; i < 64; i++) begin
            send(8'hAA, (i == 63), 1'b0);
        end
        wait_done(n);
        chk("b64_cnt", match_cnt, 255);

        // Full FF/05 frame
        send(8'hFF, 1'b0, 1'b0);
        send(8'h05, 1'b1, 1'b0);
        wait_done(n);
        chk("ff05_cnt", match_cnt, 1);

        // Reset at the 4th SHIFT cycle of an FF/05 frame
        send(8'hFF, 1'b0, 1'b0);
        tick(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy",  busy,      0);
        chk("mr_ready", in_ready,  1);
        chk("mr_done",  done,      0);
        chk("mr_cnt",   match_cnt, 0);
        seen = 0;
        repeat (15) begin
            tick();
            if (done) seen++;
        end
        chk("mr_no_done", seen, 0);
        send(8'h05, 1'b1, 1'b0);
        wait_done(n);
        chk("mr_next_cnt", match_cnt, 1);

        // Reset with a non-zero partial count
        send(8'hAA, 1'b0, 1'b0);
        tick(5);
        chk("mr2_partial", match_cnt, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr2_cnt",  match_cnt, 0);
        chk("mr2_busy", busy,      0);
        tick(12);
        chk("mr2_no_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
